// File: rtl/param_store_queue_if.sv
// Handshake bundle between the load/store unit and param_store_queue.
// The master side is the pipeline/memory environment; the slave side is the queue.
interface param_store_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [ADDR_W-1:0] alloc_addr;
  logic [DATA_W-1:0] alloc_data;
  logic [ROB_W-1:0]  alloc_rob;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_stall;
  logic              retire_valid;
  logic [ROB_W-1:0]  retire_rob;
  logic              flush_valid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic [CNT_W-1:0]  count;
  logic              empty;

  modport master (
    output alloc_valid, alloc_addr, alloc_data, alloc_rob, ld_valid, ld_addr,
           retire_valid, retire_rob, flush_valid, mem_ack,
    input  alloc_ready, fwd_hit, fwd_data, ld_stall, mem_req, mem_addr, mem_data,
           count, empty
  );

  modport slave (
    input  alloc_valid, alloc_addr, alloc_data, alloc_rob, ld_valid, ld_addr,
           retire_valid, retire_rob, flush_valid, mem_ack,
    output alloc_ready, fwd_hit, fwd_data, ld_stall, mem_req, mem_addr, mem_data,
           count, empty
  );
endinterface

// File: rtl/param_store_queue.sv
// Age-ordered store queue: holds stores until retire, drains them in order, and
// looks up the youngest matching store for loads. Define PSQ_FWD_EN to forward data.
module param_store_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  param_store_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_com;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ROB_W-1:0]  r_rob  [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_alloc_ready;
  logic              w_alloc;
  logic              w_mem_req;
  logic              w_pop;
  logic [DEPTH-1:0]  w_com_nxt;
  logic [CW-1:0]     w_ccnt;
  logic              w_found;
  logic [PW-1:0]     w_idx;
`ifdef PSQ_FWD_EN
  logic [PW-1:0]     w_sel;
`endif

  assign w_alloc_ready = (r_count < CW'(DEPTH));
  assign w_alloc       = bus.alloc_valid && w_alloc_ready && !bus.flush_valid;
  assign w_mem_req     = r_vld[r_head] && r_com[r_head] && !bus.ld_valid;
  assign w_pop         = w_mem_req && bus.mem_ack;

  // Retire marks are folded in before the flush looks at committed state.
  always_comb begin
    w_com_nxt = r_com;
    w_ccnt    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.retire_valid && r_vld[i] && !r_com[i] && (r_rob[i] == bus.retire_rob))
        w_com_nxt[i] = 1'b1;
      if (r_vld[i] && w_com_nxt[i])
        w_ccnt = w_ccnt + 1'b1;
    end
  end

  // Walk backward from tail so the first hit is the youngest matching store.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
`ifdef PSQ_FWD_EN
    w_sel   = '0;
`endif
    for (int k = 1; k <= DEPTH; k++) begin
      w_idx = r_tail - PW'(k);
      if (!w_found && r_vld[w_idx] && (r_addr[w_idx] == bus.ld_addr)) begin
        w_found = 1'b1;
`ifdef PSQ_FWD_EN
        w_sel   = w_idx;
`endif
      end
    end
  end

`ifdef PSQ_FWD_EN
  assign bus.fwd_hit  = bus.ld_valid && w_found;
  assign bus.fwd_data = (bus.ld_valid && w_found) ? r_data[w_sel] : '0;
  assign bus.ld_stall = 1'b0;
`else
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
  assign bus.ld_stall = bus.ld_valid && w_found;
`endif

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = r_addr[r_head];
  assign bus.mem_data    = r_data[r_head];
  assign bus.count       = r_count;
  assign bus.empty       = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_com   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_com <= w_com_nxt;
      if (bus.flush_valid) begin
        r_vld   <= r_vld & w_com_nxt;
        r_tail  <= r_head + w_ccnt[PW-1:0];
        r_count <= w_ccnt - CW'(w_pop);
      end else begin
        if (w_alloc) begin
          r_vld[r_tail] <= 1'b1;
          r_com[r_tail] <= 1'b0;
          r_tail        <= r_tail + 1'b1;
        end
        r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      end
      // A pop always completes, even alongside a flush.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_com[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= bus.alloc_addr;
      r_data[r_tail] <= bus.alloc_data;
      r_rob[r_tail]  <= bus.alloc_rob;
    end
  end
endmodule

// File: tb/tb_param_store_queue.sv
// Directed bench for param_store_queue; memory writes are checked by a scoreboard
// monitor, lookup/occupancy results inline against hand-computed values.
module tb_param_store_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
`ifdef PSQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_store_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) bus ();

  param_store_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.alloc_addr   = '0;
    bus.alloc_data   = '0;
    bus.alloc_rob    = '0;
    bus.ld_valid     = 1'b0;
    bus.ld_addr      = '0;
    bus.retire_valid = 1'b0;
    bus.retire_rob   = '0;
    bus.flush_valid  = 1'b0;
    bus.mem_ack      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    idle();
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic alloc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [ROB_W-1:0] r);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = a;
    bus.alloc_data  = d;
    bus.alloc_rob   = r;
  endtask

  task automatic retire(input logic [ROB_W-1:0] r);
    bus.retire_valid = 1'b1;
    bus.retire_rob   = r;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Lookup result depends on the build: forward the data, or ask for a replay.
  task automatic chk_ld(input string nm, input bit hit, input logic [DATA_W-1:0] d);
    chk({nm, "_fwd_hit"}, 64'(bus.fwd_hit), 64'(FWD && hit));
    chk({nm, "_fwd_data"}, 64'(bus.fwd_data), (FWD && hit) ? 64'(d) : 64'd0);
    chk({nm, "_ld_stall"}, 64'(bus.ld_stall), 64'(!FWD && hit));
  endtask

  // Scoreboard monitor: every accepted write must match the next expected store.
  always @(negedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                 bus.mem_addr, bus.mem_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mem_addr", 64'(bus.mem_addr), 64'(e.a));
        chk("mem_data", 64'(bus.mem_data), 64'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mid();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    chk("rst_fwd_data", 64'(bus.fwd_data), 64'd0);
    chk("rst_ld_stall", 64'(bus.ld_stall), 64'd0);
    step();

    // Fill to DEPTH, then refuse one more.
    for (int i = 0; i < 4; i++) begin
      alloc(ADDR_W'(16'h100 + 4 * i), DATA_W'(32'h1000 + i), ROB_W'(i + 1));
      mid();
      chk("fill_ready", 64'(bus.alloc_ready), 64'd1);
      step();
    end
    alloc(16'h1F0, 32'hDEAD, 4'd9);
    mid();
    chk("full_ready", 64'(bus.alloc_ready), 64'd0);
    chk("full_count", 64'(bus.count), 64'd4);
    step();
    for (int i = 0; i < 4; i++) expect_wr(ADDR_W'(16'h100 + 4 * i), DATA_W'(32'h1000 + i));
    retire(4'd1);
    bus.mem_ack = 1'b1;
    mid();
    chk("retire_latency_req", 64'(bus.mem_req), 64'd0);
    step();
    for (int k = 2; k <= 5; k++) begin
      if (k <= 4) retire(ROB_W'(k));
      if (k == 2) alloc(16'h1F4, 32'hBEEF, 4'd9);
      bus.mem_ack = 1'b1;
      mid();
      chk("drain_req", 64'(bus.mem_req), 64'd1);
      if (k == 2) chk("full_pop_ready", 64'(bus.alloc_ready), 64'd0);
      step();
    end
    mid();
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_count", 64'(bus.count), 64'd0);
    step();

    // Youngest-match lookup.
    alloc(16'h10, 32'hAAAA, 4'd5);
    load(16'h10);
    mid();
    chk_ld("same_cycle_alloc", 1'b0, 32'h0);
    step();
    alloc(16'h10, 32'hBBBB, 4'd6);
    load(16'h10);
    mid();
    chk_ld("older_only", 1'b1, 32'hAAAA);
    step();
    alloc(16'h20, 32'hCCCC, 4'd7);
    load(16'h10);
    mid();
    chk_ld("youngest", 1'b1, 32'hBBBB);
    step();
    load(16'h10);
    mid();
    chk_ld("youngest_skip_nonmatch", 1'b1, 32'hBBBB);
    step();
    load(16'h14);
    mid();
    chk_ld("miss", 1'b0, 32'h0);
    step();
    load(16'h20);
    mid();
    chk_ld("hit_c", 1'b1, 32'hCCCC);
    step();
    bus.ld_addr = 16'h10;
    mid();
    chk("no_ld_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    chk("no_ld_stall", 64'(bus.ld_stall), 64'd0);
    step();

    // Load owns the memory port.
    expect_wr(16'h10, 32'hAAAA);
    expect_wr(16'h10, 32'hBBBB);
    expect_wr(16'h20, 32'hCCCC);
    retire(4'd5);
    bus.mem_ack = 1'b1;
    step();
    retire(4'd6);
    load(16'h30);
    bus.mem_ack = 1'b1;
    mid();
    chk("ld_blocks_req", 64'(bus.mem_req), 64'd0);
    step();
    retire(4'd7);
    bus.mem_ack = 1'b1;
    mid();
    chk("ld_release_req", 64'(bus.mem_req), 64'd1);
    step();
    bus.mem_ack = 1'b1;
    step();
    load(16'h10);
    bus.mem_ack = 1'b1;
    mid();
    chk_ld("after_drain", 1'b0, 32'h0);
    step();
    bus.mem_ack = 1'b1;
    step();
    mid();
    chk("fwd_phase_empty", 64'(bus.empty), 64'd1);
    step();

    // Flush with a same-cycle retire and a dropped alloc.
    for (int i = 0; i < 4; i++) begin
      alloc(ADDR_W'(16'h200 + 4 * i), DATA_W'(32'h5000 + i), ROB_W'(5 + i));
      step();
    end
    retire(4'd5);
    step();
    retire(4'd6);
    bus.flush_valid = 1'b1;
    alloc(16'h300, 32'h9999, 4'd10);
    step();
    load(16'h208);
    mid();
    chk("flush_count", 64'(bus.count), 64'd2);
    chk_ld("flushed_rob7", 1'b0, 32'h0);
    step();
    load(16'h20C);
    mid();
    chk_ld("flushed_rob8", 1'b0, 32'h0);
    step();
    load(16'h300);
    mid();
    chk_ld("flush_dropped_alloc", 1'b0, 32'h0);
    step();
    alloc(16'h210, 32'h7777, 4'd9);
    step();
    load(16'h210);
    mid();
    chk_ld("post_flush_alloc", 1'b1, 32'h7777);
    chk("post_flush_count", 64'(bus.count), 64'd3);
    step();
    expect_wr(16'h200, 32'h5000);
    expect_wr(16'h204, 32'h5001);
    expect_wr(16'h210, 32'h7777);
    retire(4'd9);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b1;
    step();
    mid();
    chk("flush_phase_empty", 64'(bus.empty), 64'd1);
    step();

    // Wrapped pointers with alloc and pop in the same cycle.
    expect_wr(16'h400, 32'h4000);
    expect_wr(16'h404, 32'h4001);
    expect_wr(16'h408, 32'h4002);
    alloc(16'h400, 32'h4000, 4'd10);
    step();
    alloc(16'h404, 32'h4001, 4'd11);
    retire(4'd10);
    step();
    alloc(16'h408, 32'h4002, 4'd12);
    bus.mem_ack = 1'b1;
    mid();
    chk("wrap_req", 64'(bus.mem_req), 64'd1);
    chk("wrap_count_before", 64'(bus.count), 64'd2);
    step();
    retire(4'd11);
    bus.mem_ack = 1'b1;
    mid();
    chk("wrap_count_after", 64'(bus.count), 64'd2);
    chk("wrap_uncommitted_req", 64'(bus.mem_req), 64'd0);
    step();
    retire(4'd12);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b1;
    step();
    mid();
    chk("wrap_empty", 64'(bus.empty), 64'd1);
    step();

    // Reset while committed stores wait to drain.
    alloc(16'h500, 32'h6000, 4'd1);
    step();
    alloc(16'h504, 32'h6001, 4'd2);
    retire(4'd1);
    step();
    retire(4'd2);
    mid();
    chk("pre_reset_req", 64'(bus.mem_req), 64'd1);
    step();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    chk("post_reset_req", 64'(bus.mem_req), 64'd0);
    chk("post_reset_count", 64'(bus.count), 64'd0);
    chk("post_reset_empty", 64'(bus.empty), 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'b1;
      mid();
      chk("post_reset_quiet", 64'(bus.mem_req), 64'd0);
      step();
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
